axil_selftest_master: RTL and testbench

//  AXI4-Lite master that sits directly upstream of the myip3 S00_AXI register slave, in place of the BFM master.
//  On start it writes C_NUM_VECTORS test words to consecutive 32-bit registers and reads each one back.
//  It compares every read word and reports pass/fail status, so the slave is tested in hardware without a BFM.

---
 rtl/axil_selftest_master_if.sv | 50 +++++
 rtl/axil_selftest_master.sv | 182 ++++++++++++++++++
 tb/tb_axil_selftest_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_selftest_master_if.sv
// AXI4-Lite bus bundle between the self-test master and the register slave.
// Master drives the VALIDs and payloads; the slave drives READYs and responses.
interface axil_selftest_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid,
    output wdata, wstrb, wvalid,
    output bready,
    output araddr, arprot, arvalid,
    output rready,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    input  wdata, wstrb, wvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    input  rready,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_selftest_master.sv
// AXI4-Lite self-test master: writes, reads back and checks a vector table.
// Define AXIL_SELFTEST_TIMEOUT_EN to add the per-wait handshake watchdog.
module axil_selftest_master #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int unsigned C_NUM_VECTORS = 4,
  parameter int unsigned C_TIMEOUT_CYCLES = 256
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  fail_index,
  output logic [31:0] fail_data,
  output logic        timeout,
  axil_selftest_master_if.master m_axi
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam logic [3:0] LAST = 4'(C_NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    IDLE, WR, WRESP, RADDR, RDATA, FIN
  } state_e;

  state_e state, state_nxt;

  logic [3:0]    idx;
  logic          aw_done, w_done, vec_fail;
  logic          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic          go, last, rd_fail, tmo_go, to_fin;
  logic [4:0]    err_nxt;
  logic [DW-1:0] word;
  logic [31:0]   base_word;
  logic [AW-1:0] addr;

  assign aw_hs = m_axi.awvalid & m_axi.awready;
  assign w_hs  = m_axi.wvalid & m_axi.wready;
  assign b_hs  = m_axi.bvalid & m_axi.bready;
  assign ar_hs = m_axi.arvalid & m_axi.arready;
  assign r_hs  = m_axi.rvalid & m_axi.rready;

  assign go   = start & ((state == IDLE) | (state == FIN));
  assign last = (idx == LAST);

  assign addr = C_BASE_ADDR + {{(AW-6){1'b0}}, idx, 2'b00};

  always_comb begin
    base_word = 32'h0;
    unique case (idx[1:0])
      2'd0: base_word = 32'h0101_FFFF;
      2'd1: base_word = 32'hABCD_0001;
      2'd2: base_word = 32'hDEAD_0011;
      2'd3: base_word = 32'hBEEF_0011;
    endcase
    word = base_word ^ {6'b0, idx[3:2], 24'h0};
  end

  assign rd_fail = vec_fail
                 | (m_axi.rresp != 2'b00)
                 | (m_axi.rdata != word);
  assign err_nxt = err_count + {4'b0, r_hs & rd_fail};

`ifdef AXIL_SELFTEST_TIMEOUT_EN
  localparam int unsigned CW = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  logic          wait_hit;
  assign wait_hit = (state inside {WR, WRESP, RADDR, RDATA})
                  & (wait_cnt == CW'(C_TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_tmo = C_TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo_go    = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = WR;
      WR:    if ((aw_done | aw_hs) & (w_done | w_hs))
               state_nxt = WRESP;
      WRESP: if (b_hs) state_nxt = RADDR;
      RADDR: if (ar_hs) state_nxt = RDATA;
      RDATA: if (r_hs) state_nxt = last ? FIN : WR;
      FIN:   state_nxt = start ? WR : IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef AXIL_SELFTEST_TIMEOUT_EN
    // a stall on the final waited cycle aborts; progress on that cycle wins
    if (wait_hit && state_nxt == state) begin
      state_nxt = FIN;
      tmo_go    = 1'b1;
    end
`endif
  end

  assign to_fin = (state_nxt == FIN) & (state != FIN);

  always_comb begin
    m_axi.awaddr  = addr;
    m_axi.awprot  = 3'b000;
    m_axi.awvalid = (state == WR) & ~aw_done;
    m_axi.wdata   = word;
    m_axi.wstrb   = '1;
    m_axi.wvalid  = (state == WR) & ~w_done;
    m_axi.bready  = (state == WRESP);
    m_axi.araddr  = addr;
    m_axi.arprot  = 3'b000;
    m_axi.arvalid = (state == RADDR);
    m_axi.rready  = (state == RDATA);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      idx        <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      vec_fail   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_index <= '0;
      fail_data  <= '0;
    end else begin
      aw_done <= (state == WR && state_nxt == WR) ? (aw_done | aw_hs) : 1'b0;
      w_done  <= (state == WR && state_nxt == WR) ? (w_done | w_hs) : 1'b0;
      if (go) begin
        idx        <= '0;
        vec_fail   <= 1'b0;
        busy       <= 1'b1;
        done       <= 1'b0;
        pass       <= 1'b0;
        err_count  <= '0;
        fail_index <= '0;
        fail_data  <= '0;
      end
      if (state == WRESP && b_hs && m_axi.bresp != 2'b00)
        vec_fail <= 1'b1;
      if (state == RDATA && r_hs) begin
        vec_fail  <= 1'b0;
        err_count <= err_nxt;
        if (rd_fail && err_count == '0) begin
          fail_index <= idx;
          fail_data  <= m_axi.rdata[31:0];
        end
        if (!last) idx <= idx + 4'd1;
      end
      if (to_fin) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_nxt == '0) & ~tmo_go & ~timeout;
      end
    end
  end

`ifdef AXIL_SELFTEST_TIMEOUT_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state_nxt != state) wait_cnt <= '0;
      else if (state inside {WR, WRESP, RADDR, RDATA})
        wait_cnt <= wait_cnt + 1'b1;
      if (go)          timeout <= 1'b0;
      else if (tmo_go) timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axil_selftest_master.sv
// Bench for axil_selftest_master: behavioural AXI4-Lite slave with random
// READY/response delays, fault injection and a vector-level reference model.
module tb_axil_selftest_master;

  localparam int N = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETN = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, timeout;
  logic [4:0]  err_count;
  logic [3:0]  fail_index;
  logic [31:0] fail_data;

  axil_selftest_master_if #(.AW(32), .DW(32)) m_axi ();

  axil_selftest_master #(
    .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(32),
    .C_BASE_ADDR(BASE),
    .C_NUM_VECTORS(N),
    .C_TIMEOUT_CYCLES(256)
  ) dut (
    .ACLK(tb_ACLK),
    .ARESETN(tb_ARESETN),
    .start(start),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .fail_index(fail_index),
    .fail_data(fail_data),
    .timeout(timeout),
    .m_axi(m_axi)
  );

  always #5 tb_ACLK = ~tb_ACLK;

  int errors = 0;
  int checks = 0;

  logic [31:0] tbl [4] = '{32'h0101FFFF, 32'hABCD0001,
                           32'hDEAD0011, 32'hBEEF0011};

  function automatic logic [31:0] exp_word(int i);
    return tbl[i % 4] ^ (32'(i / 4) << 24);
  endfunction

  // slave configuration
  int          max_dly = 0;
  bit          aw_after_w = 0;
  bit          aw_stall = 0;
  int          corrupt_idx = -1;
  logic [31:0] corrupt_val = '0;
  int          bresp_idx = -1;

  // slave state
  bit          aw_f, w_f, b_f, ar_f, r_f;
  bit          aw_got, w_got, b_pend, r_pend;
  bit          p_awv, p_wv, p_arv;
  logic [31:0] aw_a, w_dat, ar_a, p_awa, p_wd, p_ara;
  logic [1:0]  bresp_val;
  int          aw_d, w_d, b_d, ar_d, r_d;
  int          stab_err = 0;
  int          ar_fire_cnt = 0;
  logic [31:0] mem [16];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] rd_addr_q [$];

  always @(negedge tb_ACLK) begin
    if (!tb_ARESETN) begin
      m_axi.awready = 0; m_axi.wready = 0; m_axi.arready = 0;
      m_axi.bvalid = 0; m_axi.bresp = 0;
      m_axi.rvalid = 0; m_axi.rresp = 0; m_axi.rdata = 0;
      aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      p_awv = 0; p_wv = 0; p_arv = 0;
      aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
    end else begin
      if (p_awv && !aw_f && (!m_axi.awvalid || m_axi.awaddr !== p_awa)) stab_err++;
      if (p_wv && !w_f && (!m_axi.wvalid || m_axi.wdata !== p_wd)) stab_err++;
      if (p_arv && !ar_f && (!m_axi.arvalid || m_axi.araddr !== p_ara)) stab_err++;
      if (aw_f) begin
        m_axi.awready = 0; aw_got = 1; aw_d = $urandom_range(0, max_dly);
        wr_addr_q.push_back(aw_a);
      end
      if (w_f) begin
        m_axi.wready = 0; w_got = 1; w_d = $urandom_range(0, max_dly);
        wr_data_q.push_back(w_dat);
      end
      if (b_f) m_axi.bvalid = 0;
      if (ar_f) begin
        m_axi.arready = 0; ar_d = $urandom_range(0, max_dly);
        r_pend = 1; r_d = $urandom_range(0, max_dly);
        rd_addr_q.push_back(ar_a);
      end
      if (r_f) m_axi.rvalid = 0;
      if (aw_got && w_got) begin
        mem[aw_a[5:2]] = w_dat;
        bresp_val = (bresp_idx == int'(aw_a >> 2)) ? 2'b10 : 2'b00;
        b_pend = 1; b_d = $urandom_range(0, max_dly);
        aw_got = 0; w_got = 0;
      end
      if (b_pend) begin
        if (b_d == 0) begin
          m_axi.bvalid = 1; m_axi.bresp = bresp_val; b_pend = 0;
        end else b_d--;
      end
      if (r_pend) begin
        if (r_d == 0) begin
          m_axi.rvalid = 1; m_axi.rresp = 2'b00;
          m_axi.rdata = (corrupt_idx == int'(ar_a >> 2)) ? corrupt_val : mem[ar_a[5:2]];
          r_pend = 0;
        end else r_d--;
      end
      if (m_axi.awvalid && !m_axi.awready && !aw_stall && (!aw_after_w || w_got)) begin
        if (aw_d == 0) m_axi.awready = 1; else aw_d--;
      end
      if (m_axi.wvalid && !m_axi.wready) begin
        if (w_d == 0) m_axi.wready = 1; else w_d--;
      end
      if (m_axi.arvalid && !m_axi.arready) begin
        if (ar_d == 0) m_axi.arready = 1; else ar_d--;
      end
      aw_f = m_axi.awvalid && m_axi.awready; if (aw_f) aw_a = m_axi.awaddr;
      w_f  = m_axi.wvalid && m_axi.wready;   if (w_f) w_dat = m_axi.wdata;
      ar_f = m_axi.arvalid && m_axi.arready; if (ar_f) begin ar_a = m_axi.araddr; ar_fire_cnt++; end
      b_f  = m_axi.bvalid && m_axi.bready;
      r_f  = m_axi.rvalid && m_axi.rready;
      p_awv = m_axi.awvalid; p_awa = m_axi.awaddr;
      p_wv  = m_axi.wvalid;  p_wd  = m_axi.wdata;
      p_arv = m_axi.arvalid; p_ara = m_axi.araddr;
    end
  end

  function automatic bit logs_ok(int n);
    if (wr_addr_q.size() != n || wr_data_q.size() != n || rd_addr_q.size() != n)
      return 0;
    for (int i = 0; i < n; i++) begin
      if (wr_addr_q[i] !== BASE + 32'(4 * i)) return 0;
      if (wr_data_q[i] !== exp_word(i)) return 0;
      if (rd_addr_q[i] !== BASE + 32'(4 * i)) return 0;
    end
    return 1;
  endfunction

  // expected outcome of a run from the injected faults
  task automatic model_run(output int e_err, output int e_idx, output logic [31:0] e_data);
    e_err = 0; e_idx = 0; e_data = 0;
    for (int i = 0; i < N; i++) begin
      bit bf, cf;
      bf = (bresp_idx == i);
      cf = (corrupt_idx == i) && (corrupt_val != exp_word(i));
      if (bf || cf) begin
        if (e_err == 0) begin
          e_idx = i;
          e_data = (corrupt_idx == i) ? corrupt_val : exp_word(i);
        end
        e_err++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge tb_ACLK); tb_ARESETN = 0;
    repeat (3) @(negedge tb_ACLK);
    tb_ARESETN = 1;
  endtask

  task automatic run(input int budget, output int cyc, output bit to, output bit busy1);
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    stab_err = 0;
    @(negedge tb_ACLK); start = 1;
    @(posedge tb_ACLK); #1; start = 0;
    busy1 = busy;
    cyc = 0; to = 0;
    while (!done) begin
      if (cyc >= budget) begin to = 1; break; end
      @(posedge tb_ACLK); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge tb_ACLK); #1;
    checks++;
    if ({busy, done, pass, timeout} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, timeout});
    end
    checks++;
    if ({err_count, fail_index, fail_data} !== '0) begin
      errors++; $display("FAIL reset_status: got %0h/%0h/%0h want 0", err_count, fail_index, fail_data);
    end
    checks++;
    if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_handshake: got %b want 00000",
        {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready});
    end
  endtask

  task automatic test_zero_wait();
    int cyc; bit to, b1;
    max_dly = 0; aw_after_w = 0; corrupt_idx = -1; bresp_idx = -1;
    run(1000, cyc, to, b1);
    checks++;
    if (to) begin errors++; $display("FAIL zw_timeout: got no done want done"); end
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL zw_busy: got %b want 1", b1); end
    checks++;
    if (cyc != 4 * N) begin errors++; $display("FAIL zw_latency: got %0d want %0d", cyc, 4 * N); end
    checks++;
    if ({pass, busy, err_count} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL zw_status: got pass=%b busy=%b err=%0d want 1 0 0", pass, busy, err_count);
    end
    checks++;
    if (logs_ok(N) !== 1'b1) begin
      errors++; $display("FAIL zw_traffic: got %0d writes first %0h want %0d writes first %0h",
        wr_data_q.size(), wr_data_q.size() ? wr_data_q[0] : 32'h0, N, exp_word(0));
    end
    checks++;
    if ({m_axi.wstrb, m_axi.awprot, m_axi.arprot} !== {4'hF, 3'b0, 3'b0}) begin
      errors++; $display("FAIL zw_strb_prot: got %h/%h/%h want f/0/0", m_axi.wstrb, m_axi.awprot, m_axi.arprot);
    end
  endtask

  task automatic test_delays();
    int cyc; bit to, b1;
    max_dly = 5; aw_after_w = 1; corrupt_idx = -1; bresp_idx = -1;
    for (int r = 0; r < 3; r++) begin
      run(1000, cyc, to, b1);
      checks++;
      if (to || pass !== 1'b1) begin errors++; $display("FAIL dly_pass[%0d]: got %b want 1", r, pass); end
      checks++;
      if (logs_ok(N) !== 1'b1) begin
        errors++; $display("FAIL dly_traffic[%0d]: got %0d writes want %0d in order", r, wr_data_q.size(), N);
      end
      checks++;
      if (stab_err != 0) begin errors++; $display("FAIL dly_stable[%0d]: got %0d drops want 0", r, stab_err); end
    end
    aw_after_w = 0;
  endtask

  task automatic test_corrupt();
    int cyc; bit to, b1;
    max_dly = 2; corrupt_idx = 2; corrupt_val = 32'hDEAD0010; bresp_idx = -1;
    run(1000, cyc, to, b1);
    checks++;
    if (to || {pass, err_count, fail_index} !== {1'b0, 5'd1, 4'd2}) begin
      errors++; $display("FAIL corrupt_status: got pass=%b err=%0d idx=%0d want 0 1 2", pass, err_count, fail_index);
    end
    checks++;
    if (fail_data !== 32'hDEAD0010) begin
      errors++; $display("FAIL corrupt_data: got %h want dead0010", fail_data);
    end
    repeat (3) @(posedge tb_ACLK); #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_hold: got %b want 1", done); end
    corrupt_idx = -1;
  endtask

  task automatic test_double_fault();
    int cyc; bit to, b1;
    max_dly = 1; bresp_idx = 1; corrupt_idx = 1; corrupt_val = exp_word(1) ^ 32'h0000_0100;
    run(1000, cyc, to, b1);
    checks++;
    if (to || {pass, err_count, fail_index} !== {1'b0, 5'd1, 4'd1}) begin
      errors++; $display("FAIL dbl_status: got pass=%b err=%0d idx=%0d want 0 1 1", pass, err_count, fail_index);
    end
    checks++;
    if (fail_data !== corrupt_val) begin
      errors++; $display("FAIL dbl_data: got %h want %h", fail_data, corrupt_val);
    end
    bresp_idx = -1; corrupt_idx = -1;
  endtask

  task automatic test_reset_mid();
    int cyc; bit to, b1, hit;
    max_dly = 0; hit = 0; ar_fire_cnt = 0;
    @(negedge tb_ACLK); start = 1;
    @(posedge tb_ACLK); #1; start = 0;
    for (int k = 0; k < 100; k++) begin
      if (m_axi.rready && ar_fire_cnt == 2) begin hit = 1; break; end
      @(posedge tb_ACLK); #1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_mid_reach: got no RDATA of vector 1 want reached"); end
    tb_ARESETN = 0;
    @(posedge tb_ACLK); #1;
    checks++;
    if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready, busy} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b want 000000",
        {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready, busy});
    end
    @(negedge tb_ACLK); @(negedge tb_ACLK); tb_ARESETN = 1;
    run(1000, cyc, to, b1);
    checks++;
    if (to || pass !== 1'b1 || logs_ok(N) !== 1'b1) begin
      errors++; $display("FAIL rst_mid_rerun: got pass=%b writes=%0d want 1 %0d", pass, wr_data_q.size(), N);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, e_err, e_idx; bit to, b1; logic [31:0] e_data;
    for (int r = 0; r < 8; r++) begin
      max_dly = $urandom_range(0, 4);
      aw_after_w = $urandom_range(0, 1);
      bresp_idx = int'($urandom_range(0, N)) - 1;
      corrupt_idx = int'($urandom_range(0, N)) - 1;
      corrupt_val = $urandom();
      model_run(e_err, e_idx, e_data);
      run(1000, cyc, to, b1);
      checks++;
      if (to || err_count !== 5'(e_err) || pass !== (e_err == 0)) begin
        errors++; $display("FAIL rand_err[%0d]: got err=%0d pass=%b want %0d %b", r, err_count, pass, e_err, e_err == 0);
      end
      checks++;
      if (fail_index !== 4'(e_idx) || fail_data !== e_data) begin
        errors++; $display("FAIL rand_first[%0d]: got %0d/%h want %0d/%h", r, fail_index, fail_data, e_idx, e_data);
      end
      checks++;
      if (logs_ok(N) !== 1'b1 || stab_err != 0) begin
        errors++; $display("FAIL rand_traffic[%0d]: got writes=%0d drops=%0d want %0d 0", r, wr_data_q.size(), stab_err, N);
      end
    end
    bresp_idx = -1; corrupt_idx = -1; aw_after_w = 0;
  endtask

`ifdef AXIL_SELFTEST_TIMEOUT_EN
  task automatic test_timeout();
    int cyc; bit to, b1;
    max_dly = 0; aw_stall = 1;
    run(400, cyc, to, b1);
    checks++;
    if (to || cyc != 256) begin errors++; $display("FAIL tmo_cycles: got %0d want 256", cyc); end
    checks++;
    if ({timeout, done, pass, m_axi.awvalid} !== 4'b1100) begin
      errors++; $display("FAIL tmo_status: got %b want 1100", {timeout, done, pass, m_axi.awvalid});
    end
    aw_stall = 0;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_delays();
    test_corrupt();
    test_double_fault();
    test_reset_mid();
    test_back_to_back();
`ifdef AXIL_SELFTEST_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
